// File: rtl/io_pkg.sv
// io_pkg: register map word offsets, CTRL bit positions and the hex-to-7-segment table.
package io_pkg;
  localparam logic [5:0] OFF_SW    = 6'h00;
  localparam logic [5:0] OFF_LED   = 6'h01;
  localparam logic [5:0] OFF_COUNT = 6'h02;
  localparam logic [5:0] OFF_CTRL  = 6'h03;
  localparam logic [5:0] OFF_LOAD  = 6'h04;
  localparam logic [5:0] OFF_SEG   = 6'h05;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IE  = 2;
  localparam int CTRL_EXP = 3;
  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] HEX7SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/io_responder_seg_scan.sv
// seg_scan: multiplexes a 32-bit value onto eight active-low hex digits.
module seg_scan
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  output logic [7:0]  an,
  output logic [7:0]  cat
);
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic        step;
  logic [3:0]  nib;
  assign step = cnt == 32'(SCAN_DIV - 1);
  assign nib  = value[{idx, 2'b00} +: 4];
  assign an   = ~(8'd1 << idx);
  assign cat  = {1'b1, HEX7SEG[nib]};
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= step ? '0 : cnt + 32'd1;
      if (step) idx <= idx + 3'd1;
    end
  end
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped switches, LEDs and down-counting timer for the CPU data port.
// Define IO_SEG_SCAN_EN to add the SEG register and the 7-segment scanner ports.
module io_responder
  import io_pkg::*;
#(
  parameter logic [23:0] IO_BASE  = 24'hFFFFFF,
  parameter int          SW_W     = 16,
  parameter int          TICK_DIV = 50000,
  parameter int          SCAN_DIV = 1000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            wmem,
  output logic [31:0]     rdata,
  output logic            io_sel,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] led,
  output logic            timer_irq
`ifdef IO_SEG_SCAN_EN
  ,
  output logic [7:0]      seg_an,
  output logic [7:0]      seg_cat
`endif
);
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [31:0] count, load, presc, seg_rd;
  logic en, ar, ie, expired;
  logic [5:0] sel;
  logic wr, wr_ctrl, tick, kill, start, unused;
  assign sel       = addr[7:2];
  assign io_sel    = addr[31:8] == IO_BASE;
  assign wr        = wmem & io_sel;
  assign wr_ctrl   = wr && sel == OFF_CTRL;
  assign tick      = en && presc == 32'(TICK_DIV - 1);
  assign kill      = wr_ctrl & ~wdata[CTRL_EN];
  assign start     = wr_ctrl & wdata[CTRL_EN] & ~en;
  assign timer_irq = expired & ie;
  assign unused    = ^{addr[1:0], SCAN_DIV > 0};
`ifdef IO_SEG_SCAN_EN
  logic [31:0] seg;
  assign seg_rd = seg;
  always_ff @(posedge clock) begin
    if (reset) seg <= '0;
    else if (wr && sel == OFF_SEG) seg <= wdata;
  end
  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock(clock), .reset(reset), .value(seg), .an(seg_an), .cat(seg_cat)
  );
`else
  assign seg_rd = '0;
`endif
  always_comb begin
    rdata = !io_sel              ? '0 :
            sel == OFF_SW    ? 32'(sw_sync) :
            sel == OFF_LED   ? 32'(led) :
            sel == OFF_COUNT ? count :
            sel == OFF_CTRL  ? {28'd0, expired, ie, ar, en} :
            sel == OFF_LOAD  ? load :
            sel == OFF_SEG   ? seg_rd : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led     <= '0;
      count   <= '0;
      load    <= '0;
      presc   <= '0;
      en      <= 1'b0;
      ar      <= 1'b0;
      ie      <= 1'b0;
      expired <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (wr && sel == OFF_LED) led <= wdata[SW_W-1:0];
      if (wr && sel == OFF_LOAD) load <= wdata;
      if (wr_ctrl) begin
        en <= wdata[CTRL_EN];
        ar <= wdata[CTRL_AR];
        ie <= wdata[CTRL_IE];
        if (wdata[CTRL_EXP]) expired <= 1'b0;
      end
      presc <= (!en || tick || kill) ? '0 : presc + 32'd1;
      // Tick handling comes last so expiry beats a same-cycle clear and a 1->1 en rewrite.
      if (start) count <= load;
      else if (tick && !kill) begin
        if (count != 0) count <= count - 32'd1;
        else begin
          expired <= 1'b1;
          if (ar) count <= load;
          else en <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed self-checking bench for io_responder (TICK_DIV=2, SCAN_DIV=1).
module tb_io_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        wmem = 1'b0;
  logic [31:0] rdata;
  logic        io_sel;
  logic [15:0] sw = '0, led;
  logic        timer_irq;
`ifdef IO_SEG_SCAN_EN
  logic [7:0]  seg_an, seg_cat;
`endif
  int errors = 0, checks = 0;
  localparam logic [31:0] B = 32'hFFFFFF00;
  always #5 clock = ~clock;
  io_responder #(.TICK_DIV(2), .SCAN_DIV(1)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wmem(wmem),
    .rdata(rdata), .io_sel(io_sel), .sw(sw), .led(led), .timer_irq(timer_irq)
`ifdef IO_SEG_SCAN_EN
    , .seg_an(seg_an), .seg_cat(seg_cat)
`endif
  );
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wmem = 1'b1;
    @(posedge clock); #1;
    wmem = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    addr = a; #1;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic test_reset;
    logic [31:0] offs [4] = '{32'h04, 32'h08, 32'h0C, 32'h10};
    reset = 1'b1; step(2); reset = 1'b0; step(1);
    foreach (offs[i]) begin
      rd(B + offs[i]); checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_read off=%h got=%h exp=0", offs[i], rdata); end
    end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led got=%h exp=0", led); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (io_sel !== 1'b1) begin errors++; $display("FAIL io_sel_hit got=%b exp=1", io_sel); end
    rd(32'h0000_1004);
    checks++; if (io_sel !== 1'b0) begin errors++; $display("FAIL io_sel_miss got=%b exp=0", io_sel); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_miss got=%h exp=0", rdata); end
  endtask
  task automatic test_sw_led;
    sw = 16'hA5C3; step(2); rd(B);
    checks++; if (rdata !== 32'h0000A5C3) begin errors++; $display("FAIL sw_read got=%h exp=0000a5c3", rdata); end
    wr(B + 32'h04, 32'h1234BEEF);
    checks++; if (led !== 16'hBEEF) begin errors++; $display("FAIL led_write got=%h exp=beef", led); end
    rd(B + 32'h05);
    checks++; if (rdata !== 32'h0000BEEF) begin errors++; $display("FAIL led_read_lowbits got=%h exp=0000beef", rdata); end
    wr(32'h0000_1004, 32'h0);
    checks++; if (led !== 16'hBEEF) begin errors++; $display("FAIL led_nonio_write got=%h exp=beef", led); end
    wr(B + 32'h18, 32'hFFFFFFFF); rd(B + 32'h18);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", rdata); end
`ifndef IO_SEG_SCAN_EN
    wr(B + 32'h14, 32'h89ABCDEF); rd(B + 32'h14);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL seg_absent_read got=%h exp=0", rdata); end
`endif
  endtask
  task automatic test_timer_oneshot;
    wr(B + 32'h10, 32'd3); rd(B + 32'h08);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL load_no_count got=%h exp=0", rdata); end
    wr(B + 32'h0C, 32'h5);
    for (int k = 3; k >= 0; k--) begin
      rd(B + 32'h08); checks++;
      if (rdata !== 32'(k)) begin errors++; $display("FAIL oneshot_count got=%0d exp=%0d", rdata, k); end
      if (k != 0) step(2);
    end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early got=%b exp=0", timer_irq); end
    step(2); rd(B + 32'h0C);
    checks++; if (rdata !== 32'hC) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=c", rdata); end
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got=%b exp=1", timer_irq); end
    step(4); rd(B + 32'h08);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL oneshot_hold got=%h exp=0", rdata); end
  endtask
  task automatic test_autoreload;
    logic [31:0] seq [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
    wr(B + 32'h0C, 32'h8); wr(B + 32'h10, 32'd1); wr(B + 32'h0C, 32'h7);
    foreach (seq[i]) begin
      rd(B + 32'h08); checks++;
      if (rdata !== seq[i]) begin errors++; $display("FAIL reload_count step=%0d got=%0d exp=%0d", i, rdata, seq[i]); end
      if (i == 2) begin
        rd(B + 32'h0C); checks++;
        if (rdata !== 32'hF) begin errors++; $display("FAIL reload_expired got=%h exp=f", rdata); end
      end
      if (i != 3) step(2);
    end
    step(1); wr(B + 32'h0C, 32'hF); rd(B + 32'h0C);
    checks++; if (rdata !== 32'hF) begin errors++; $display("FAIL w1c_same_cycle got=%h exp=f", rdata); end
    step(4); wr(B + 32'h0C, 32'hF); rd(B + 32'h0C);
    checks++; if (rdata !== 32'h7) begin errors++; $display("FAIL w1c_next_cycle got=%h exp=7", rdata); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", timer_irq); end
  endtask
  task automatic test_reset_mid;
    wr(B + 32'h0C, 32'h8); wr(B + 32'h10, 32'd2); wr(B + 32'h0C, 32'h1); rd(B + 32'h08);
    checks++; if (rdata !== 32'd2) begin errors++; $display("FAIL mid_setup got=%0d exp=2", rdata); end
    reset = 1'b1; step(1); rd(B + 32'h08);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", rdata); end
    rd(B + 32'h0C);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_ctrl got=%h exp=0", rdata); end
    rd(B + 32'h10);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_load got=%h exp=0", rdata); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b exp=0", timer_irq); end
    reset = 1'b0; step(1);
  endtask
`ifdef IO_SEG_SCAN_EN
  task automatic test_seg_scan;
    logic [7:0] exp_cat [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    int found = 0;
    wr(B + 32'h14, 32'h89ABCDEF); rd(B + 32'h14);
    checks++; if (rdata !== 32'h89ABCDEF) begin errors++; $display("FAIL seg_read got=%h exp=89abcdef", rdata); end
    for (int n = 0; n < 16 && found == 0; n++) begin
      if (seg_an === 8'hFE) found = 1; else step(1);
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL seg_find_digit0 got=%h exp=fe", seg_an); end
    else for (int k = 0; k < 9; k++) begin
      checks++;
      if (seg_an !== ~(8'd1 << (k % 8))) begin errors++; $display("FAIL seg_an step=%0d got=%h exp=%h", k, seg_an, ~(8'd1 << (k % 8))); end
      checks++;
      if (seg_cat !== exp_cat[k % 8]) begin errors++; $display("FAIL seg_cat step=%0d got=%h exp=%h", k, seg_cat, exp_cat[k % 8]); end
      step(1);
    end
  endtask
`endif
  initial begin
    test_reset;
    test_sw_led;
    test_timer_oneshot;
    test_autoreload;
    test_reset_mid;
`ifdef IO_SEG_SCAN_EN
    test_seg_scan;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O responder for the single-cycle CPU's data port.
- Decodes the CPU's data address, write strobe and store data. Returns read data in the same cycle so `lw` completes in one period.
- Holds the board-facing state: switch sampling, LED register, a down-counting timer with interrupt flag, and an optional 7-segment scanner.
- Sits beside data memory. The top level selects `rdata` over memory data when `io_sel`=1.

Parameters:
- IO_BASE, 24'hFFFFFF: value of addr[31:8] that selects the IO region. This is reachable by a sign-extended negative offset from r0.
- SW_W, 16: switch/LED width (1..32).
- TICK_DIV, 50000: clocks per timer tick (>=1).
- SCAN_DIV, 1000: clocks per 7-seg digit step. Used only with IO_SEG_SCAN_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- addr  in  32  CPU data address (ALU result).
- wdata  in  32  CPU store data.
- wmem  in  1  CPU store strobe.
- rdata  out  32  read data, combinational.
- io_sel  out  1  combinational; 1 when addr[31:8]==IO_BASE.
- sw  in  SW_W  asynchronous board switches.
- led  out  SW_W  LED register.
- timer_irq  out  1  = CTRL.expired & CTRL.ie.
- seg_an  out  8  digit enables, active-low. Present only with IO_SEG_SCAN_EN.
- seg_cat  out  8  segments a-g + dp, active-low. Present only with IO_SEG_SCAN_EN.

Behaviour:
- Register select is addr[7:2]; addr[1:0] are ignored.
- Write occurs on the rising edge when wmem & io_sel; the effect is visible in the next cycle.
- Reads are combinational from current state. Unmapped offsets read 0 and ignore writes.
- Register map:
  - 0x00 SW (RO): sw passed through a 2-flop synchronizer, zero-extended.
  - 0x04 LED (RW): led[SW_W-1:0].
  - 0x08 COUNT (RO): 32-bit timer count.
  - 0x0C CTRL (RW): bit0 en, bit1 auto-reload, bit2 ie, bit3 expired (read; write-1-to-clear). Other bits read 0.
  - 0x10 LOAD (RW): 32-bit reload value.
  - 0x14 SEG (RW): 32-bit value shown as 8 hex digits.
- Timer:
  - Prescaler counts 0..TICK_DIV-1 while en=1. It is held at 0 while en=0.
  - tick = prescaler==TICK_DIV-1.
  - On tick with COUNT!=0: COUNT -= 1.
  - On tick with COUNT==0: expired<=1. If auto-reload, COUNT<=LOAD; otherwise en<=0.
  - Writing CTRL with en 0->1 copies LOAD into COUNT and clears the prescaler.
  - Writing LOAD does not touch COUNT.
- Simultaneous events:
  - Expiry set wins over a same-cycle W1C of expired.
  - A same-cycle CTRL write of en=0 wins over a tick: no decrement, no expiry.
- Reset: LED=0, COUNT=0, LOAD=0, CTRL=0, SEG=0, prescaler=0, synchronizer flops=0, timer_irq=0.
- Reset mid-count aborts the timer immediately.

Optional Feature:
- IO_SEG_SCAN_EN defined:
  - seg_scan sub-module drives seg_an/seg_cat.
  - Active digit index advances 0..7 every SCAN_DIV clocks and wraps 7->0.
  - Digit i shows SEG[4i+3:4i] in hex. dp is always off (1).
  - Reset sets index 0, seg_an=8'hFE, seg_cat showing nibble 0.
- IO_SEG_SCAN_EN undefined:
  - seg_an/seg_cat ports and the scanner are absent.
  - Offset 0x14 reads 0 and writes are ignored.

Decomposition:
- Shared package io_pkg holds:
  - register offset constants: OFF_SW, OFF_LED, OFF_COUNT, OFF_CTRL, OFF_LOAD, OFF_SEG;
  - CTRL bit indices;
  - the hex-to-7-seg constant table.
- One sub-module, seg_scan (clock, reset, value[31:0] -> an, cat), instantiated only under IO_SEG_SCAN_EN.

Test Plan:
- Reset applied, then released -> rdata at addr 0xFFFFFF04/08/0C/10 = 0; led=0; timer_irq=0. At 0x00001004: io_sel=0, rdata=0.
- sw=16'hA5C3 held 2 clocks -> read 0xFFFFFF00 returns 32'h0000A5C3. Store 32'h1234_BEEF to 0xFFFFFF04 -> next cycle led=16'hBEEF.
- TICK_DIV=2, LOAD=3, CTRL=0x5 (en, ie; auto-reload off) -> COUNT 3,2,1,0 at 2-clock steps; then expired=1, timer_irq=1, en=0, COUNT stays 0.
- Auto-reload: LOAD=1, CTRL=0x7 -> COUNT cycles 1,0,1,0 and expired stays set. Write CTRL=0x8|0x7 in the expiry cycle -> expired remains 1. Write it one cycle later -> expired=0.
- Reset asserted with COUNT=2 and en=1 -> next cycle COUNT=0, CTRL=0, timer_irq=0.
- IO_SEG_SCAN_EN, SCAN_DIV=1, SEG=32'h89AB_CDEF -> seg_an steps FE,FD,...,7F,FE. seg_cat shows F on digit 0 and 8 on digit 7.
